// File: rtl/r_order_ctrl_if.sv
// rtl/r_order_ctrl_if.sv - AR capture, R routing and status signals of the read-order controller
interface r_order_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                     ar_fire;
  logic [2:0]               ar_slv_sel;
  logic [7:0]               ar_len;
  logic                     ar_allow;
  logic                     m_RVALID;
  logic                     m_RREADY;
  logic                     m_RLAST;
  logic [2:0]               R_SLV_sel;
  logic                     R_hold;
  logic [$clog2(DEPTH):0]   outstanding;
  logic                     sel_err;
  logic                     r_len_err;
  logic                     r_timeout_err;

  modport master (
    output ar_fire, ar_slv_sel, ar_len, m_RVALID, m_RREADY, m_RLAST,
    input  ar_allow, R_SLV_sel, R_hold, outstanding, sel_err, r_len_err, r_timeout_err
  );

  modport slave (
    input  ar_fire, ar_slv_sel, ar_len, m_RVALID, m_RREADY, m_RLAST,
    output ar_allow, R_SLV_sel, R_hold, outstanding, sel_err, r_len_err, r_timeout_err
  );
endinterface

// File: rtl/r_order_ctrl.sv
// rtl/r_order_ctrl.sv - in-order read-data routing controller; watchdog compiled in by R_ORDER_TIMEOUT_EN
module r_order_ctrl #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset_n,
  r_order_ctrl_if.slave bus
);
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW:0]      CNT_FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SWITCH} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_sel_mem [DEPTH];
  logic [7:0]    r_len_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr, w_rptr_inc;
  logic [AW:0]   r_count;
  logic [7:0]    r_beat_cnt;
  logic [2:0]    r_sel, w_sel_nxt;
  logic          r_hold, w_hold_nxt;
  logic          r_sel_err, r_len_err;
  logic          w_allow, w_push, w_xfer, w_beat, w_nonempty, w_cnt_last, w_pop, w_tmo_pop;

  assign w_allow    = r_count < CNT_FULL;
  assign w_nonempty = r_count != '0;
  assign w_push     = bus.ar_fire && w_allow && (bus.ar_slv_sel <= 3'd4);
  assign w_xfer     = bus.m_RVALID && bus.m_RREADY;
  assign w_beat     = w_xfer && w_nonempty && !r_hold;
  assign w_cnt_last = r_beat_cnt == r_len_mem[r_rptr];
  assign w_pop      = (w_beat && (bus.m_RLAST || w_cnt_last)) || w_tmo_pop;
  assign w_rptr_inc = r_rptr + PTR_ONE;

`ifdef R_ORDER_TIMEOUT_EN
  localparam int            WW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_ONE = 1;
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] r_wdog;
  logic          r_tmo_err;

  assign w_tmo_pop = (r_state == S_ACTIVE) && !w_beat && (r_wdog == WD_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_tmo_pop) r_tmo_err <= 1'b1;
      if ((r_state != S_ACTIVE) || w_beat || w_pop) r_wdog <= '0;
      else r_wdog <= r_wdog + WD_ONE;
    end
  end
  assign bus.r_timeout_err = r_tmo_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo      = (TIMEOUT_CYCLES == 0);
  assign w_tmo_pop         = 1'b0;
  assign bus.r_timeout_err = 1'b0;
`endif

  // Queue storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sel_mem[r_wptr] <= bus.ar_slv_sel;
      r_len_mem[r_wptr] <= bus.ar_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
      r_sel_err  <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= w_rptr_inc;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      if (w_pop)       r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
      r_sel_err <= bus.ar_fire && w_allow && (bus.ar_slv_sel > 3'd4);
      // Stray beats and RLAST disagreeing with the recorded length are both sticky errors.
      r_len_err <= r_len_err || (w_xfer && !w_beat) || (w_beat && (bus.m_RLAST != w_cnt_last));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_hold  <= 1'b1;
      r_sel   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      S_IDLE: begin
        w_hold_nxt = 1'b1;
        if (w_push) begin
          w_state_nxt = S_ACTIVE;
          w_hold_nxt  = 1'b0;
          w_sel_nxt   = bus.ar_slv_sel;
        end
      end
      S_ACTIVE: begin
        w_hold_nxt = 1'b0;
        w_sel_nxt  = r_sel_mem[r_rptr];
        if (w_pop) begin
          w_state_nxt = S_SWITCH;
          w_hold_nxt  = 1'b1;
          // With one entry left, a simultaneous push becomes the new head before it is stored.
          if (r_count > CNT_ONE) w_sel_nxt = r_sel_mem[w_rptr_inc];
          else if (w_push)       w_sel_nxt = bus.ar_slv_sel;
          else                   w_sel_nxt = r_sel;
        end
      end
      S_SWITCH: begin
        if (w_nonempty) begin
          w_state_nxt = S_ACTIVE;
          w_hold_nxt  = 1'b0;
          w_sel_nxt   = r_sel_mem[r_rptr];
        end else if (w_push) begin
          w_state_nxt = S_ACTIVE;
          w_hold_nxt  = 1'b0;
          w_sel_nxt   = bus.ar_slv_sel;
        end else begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = 1'b1;
      end
    endcase
  end

  assign bus.ar_allow    = w_allow;
  assign bus.R_SLV_sel   = r_sel;
  assign bus.R_hold      = r_hold;
  assign bus.outstanding = r_count;
  assign bus.sel_err     = r_sel_err;
  assign bus.r_len_err   = r_len_err;
endmodule

// File: tb/tb_r_order_ctrl.sv
// tb/tb_r_order_ctrl.sv - directed self-checking bench for r_order_ctrl
module tb_r_order_ctrl;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  r_order_ctrl_if #(.DEPTH(4)) bus ();

  r_order_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ar_fire    = 1'b0;
    bus.ar_slv_sel = 3'd0;
    bus.ar_len     = 8'd0;
    bus.m_RVALID   = 1'b0;
    bus.m_RREADY   = 1'b0;
    bus.m_RLAST    = 1'b0;
  endtask

  task automatic push(input logic [2:0] sel, input logic [7:0] len);
    bus.ar_fire    = 1'b1;
    bus.ar_slv_sel = sel;
    bus.ar_len     = len;
  endtask

  task automatic beat(input logic last);
    bus.m_RVALID = 1'b1;
    bus.m_RREADY = 1'b1;
    bus.m_RLAST  = last;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("rst_hold", bus.R_hold, 1);
    chk("rst_sel", bus.R_SLV_sel, 0);
    chk("rst_allow", bus.ar_allow, 1);
    chk("rst_outst", bus.outstanding, 0);
    chk("rst_sel_err", bus.sel_err, 0);
    chk("rst_len_err", bus.r_len_err, 0);
    chk("rst_tmo_err", bus.r_timeout_err, 0);

    // single burst sel=2 len=3
    push(3'd2, 8'd3);
    tick();
    idle_inputs();
    chk("b1_sel", bus.R_SLV_sel, 2);
    chk("b1_hold", bus.R_hold, 0);
    chk("b1_outst", bus.outstanding, 1);
    beat(1'b0);
    tick();
    tick();
    chk("b1_mid_hold", bus.R_hold, 0);
    chk("b1_mid_outst", bus.outstanding, 1);
    tick();
    beat(1'b1);
    tick();
    idle_inputs();
    chk("b1_end_hold", bus.R_hold, 1);
    chk("b1_end_outst", bus.outstanding, 0);
    chk("b1_end_len_err", bus.r_len_err, 0);
    tick();

    // illegal slave select
    push(3'd5, 8'd0);
    tick();
    idle_inputs();
    chk("sel5_err", bus.sel_err, 1);
    chk("sel5_outst", bus.outstanding, 0);
    chk("sel5_hold", bus.R_hold, 1);
    tick();
    chk("sel5_err_drop", bus.sel_err, 0);

    // fill the queue: sels 1,3,4,0
    push(3'd1, 8'd0);
    tick();
    chk("fill1_allow", bus.ar_allow, 1);
    push(3'd3, 8'd0);
    tick();
    push(3'd4, 8'd0);
    tick();
    chk("fill3_allow", bus.ar_allow, 1);
    push(3'd0, 8'd0);
    tick();
    chk("full_allow", bus.ar_allow, 0);
    chk("full_outst", bus.outstanding, 4);
    chk("full_sel", bus.R_SLV_sel, 1);
    push(3'd2, 8'd0);
    tick();
    idle_inputs();
    chk("fifth_outst", bus.outstanding, 4);
    chk("fifth_sel_err", bus.sel_err, 0);

    // drain with one bubble between bursts
    beat(1'b1);
    tick();
    idle_inputs();
    chk("d1_hold", bus.R_hold, 1);
    chk("d1_sel", bus.R_SLV_sel, 3);
    chk("d1_allow", bus.ar_allow, 1);
    chk("d1_outst", bus.outstanding, 3);
    tick();
    chk("d2_hold", bus.R_hold, 0);
    chk("d2_sel", bus.R_SLV_sel, 3);
    beat(1'b1);
    tick();
    idle_inputs();
    chk("d3_hold", bus.R_hold, 1);
    chk("d3_sel", bus.R_SLV_sel, 4);
    tick();
    chk("d4_hold", bus.R_hold, 0);
    chk("d4_sel", bus.R_SLV_sel, 4);
    beat(1'b1);
    tick();
    idle_inputs();
    chk("d5_hold", bus.R_hold, 1);
    chk("d5_sel", bus.R_SLV_sel, 0);
    tick();
    chk("d6_hold", bus.R_hold, 0);
    chk("d6_sel", bus.R_SLV_sel, 0);
    chk("d6_outst", bus.outstanding, 1);
    beat(1'b1);
    tick();
    idle_inputs();
    chk("d7_outst", bus.outstanding, 0);
    chk("d7_hold", bus.R_hold, 1);
    tick();
    chk("d8_hold", bus.R_hold, 1);
    chk("d8_outst", bus.outstanding, 0);
    chk("drain_len_err", bus.r_len_err, 0);

    // early RLAST on a len=1 burst, then a clean burst
    push(3'd1, 8'd1);
    tick();
    push(3'd4, 8'd0);
    tick();
    idle_inputs();
    beat(1'b1);
    tick();
    idle_inputs();
    chk("early_len_err", bus.r_len_err, 1);
    chk("early_outst", bus.outstanding, 1);
    chk("early_hold", bus.R_hold, 1);
    chk("early_sel", bus.R_SLV_sel, 4);
    tick();
    chk("after_hold", bus.R_hold, 0);
    chk("after_sel", bus.R_SLV_sel, 4);
    beat(1'b1);
    tick();
    idle_inputs();
    chk("after_outst", bus.outstanding, 0);
    chk("after_len_err", bus.r_len_err, 1);
    tick();

    // reset mid-burst
    push(3'd3, 8'd3);
    tick();
    idle_inputs();
    chk("mb_sel", bus.R_SLV_sel, 3);
    beat(1'b0);
    tick();
    tick();
    idle_inputs();
    chk("mb_outst", bus.outstanding, 1);
    reset_n = 1'b0;
    tick();
    chk("mbr_hold", bus.R_hold, 1);
    chk("mbr_sel", bus.R_SLV_sel, 0);
    chk("mbr_allow", bus.ar_allow, 1);
    chk("mbr_outst", bus.outstanding, 0);
    chk("mbr_len_err", bus.r_len_err, 0);
    chk("mbr_sel_err", bus.sel_err, 0);
    chk("mbr_tmo_err", bus.r_timeout_err, 0);
    reset_n = 1'b1;
    tick();

    // stray beat on an empty queue
    beat(1'b1);
    tick();
    idle_inputs();
    chk("stray_len_err", bus.r_len_err, 1);
    chk("stray_outst", bus.outstanding, 0);
    chk("stray_hold", bus.R_hold, 1);
    tick();

    // stalled burst
    push(3'd0, 8'd0);
    tick();
    idle_inputs();
    repeat (15) tick();
    chk("stall15_tmo", bus.r_timeout_err, 0);
    chk("stall15_outst", bus.outstanding, 1);
`ifdef R_ORDER_TIMEOUT_EN
    tick();
    chk("tmo_err", bus.r_timeout_err, 1);
    chk("tmo_outst", bus.outstanding, 0);
    chk("tmo_hold", bus.R_hold, 1);
    tick();
    chk("tmo_idle_hold", bus.R_hold, 1);
`else
    repeat (40) tick();
    chk("stall_tmo", bus.r_timeout_err, 0);
    chk("stall_sel", bus.R_SLV_sel, 0);
    chk("stall_hold", bus.R_hold, 0);
    chk("stall_outst", bus.outstanding, 1);
    beat(1'b1);
    tick();
    idle_inputs();
    chk("stall_drain_outst", bus.outstanding, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
